// File: rtl/reg_file_read_unit.sv
// Integer register file with two registered read ports feeding ID/EX.
// Same-edge write-back is forwarded to the read ports.
module reg_file_read_unit #(
    parameter int unsigned          DATA_W  = 32,
    parameter int unsigned          ADDR_W  = 5,
    parameter logic [DATA_W-1:0]    SP_INIT = 32'h0000_3FFC,
    parameter logic [DATA_W-1:0]    GP_INIT = 32'h0000_1800
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic              rdEn,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    output logic              readValid
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DATA_W-1:0] rd1_nxt;
    logic [DATA_W-1:0] rd2_nxt;
    logic              wr_en;

    assign wr_en = regWrite && (writeReg != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            regs[28] <= GP_INIT;
            regs[29] <= SP_INIT;
        end else if (wr_en) begin
            regs[writeReg] <= writeData;
        end
    end

    // r0 is forced to zero before the bypass so a write to r0 never leaks out
    always_comb begin
        rd1_nxt = regs[readReg1];
        rd2_nxt = regs[readReg2];
        if (readReg1 == '0) begin
            rd1_nxt = '0;
        end else if (wr_en && (writeReg == readReg1)) begin
            rd1_nxt = writeData;
        end
        if (readReg2 == '0) begin
            rd2_nxt = '0;
        end else if (wr_en && (writeReg == readReg2)) begin
            rd2_nxt = writeData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readData1 <= '0;
            readData2 <= '0;
            readValid <= 1'b0;
        end else begin
            readValid <= rdEn;
            if (rdEn) begin
                readData1 <= rd1_nxt;
                readData2 <= rd2_nxt;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_read_unit.sv
// Randomized self-checking bench for reg_file_read_unit.
// Reference: plain array of register values plus expected output latches.
module tb_reg_file_read_unit;

    localparam logic [31:0] SP = 32'h0000_3FFC;
    localparam logic [31:0] GP = 32'h0000_1800;

    logic        clk;
    logic        reset;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        rdEn;
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic        readValid;

    int checks;
    int failures;

    logic [31:0] m [32];
    logic [31:0] e1;
    logic [31:0] e2;
    logic        ev;

    reg_file_read_unit dut (
        .clk       (clk),
        .reset     (reset),
        .regWrite  (regWrite),
        .writeReg  (writeReg),
        .writeData (writeData),
        .rdEn      (rdEn),
        .readReg1  (readReg1),
        .readReg2  (readReg2),
        .readData1 (readData1),
        .readData2 (readData2),
        .readValid (readValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic mreset();
        for (int i = 0; i < 32; i++) m[i] = '0;
        m[28] = GP;
        m[29] = SP;
        e1 = '0;
        e2 = '0;
        ev = 1'b0;
    endtask

    task automatic check_out(input string tag);
        check({tag, ".rd1"}, readData1, e1);
        check({tag, ".rd2"}, readData2, e2);
        check({tag, ".vld"}, {31'b0, readValid}, {31'b0, ev});
    endtask

    function automatic logic [31:0] rd_model(input logic [4:0] a,
                                             input logic we,
                                             input logic [4:0] wa,
                                             input logic [31:0] wd);
        if (a == 0) return '0;
        if (we && wa == a) return wd;
        return m[a];
    endfunction

    task automatic cyc(input string tag, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic re,
                       input logic [4:0] a1, input logic [4:0] a2);
        regWrite  = we;
        writeReg  = wa;
        writeData = wd;
        rdEn      = re;
        readReg1  = a1;
        readReg2  = a2;
        @(posedge clk);
        if (re) begin
            e1 = rd_model(a1, we, wa, wd);
            e2 = rd_model(a2, we, wa, wd);
        end
        ev = re;
        if (we && wa != 0) m[wa] = wd;
        #1;
        check_out(tag);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        regWrite = 1'b0;
        writeReg = '0;
        writeData = '0;
        rdEn     = 1'b0;
        readReg1 = '0;
        readReg2 = '0;
        mreset();
        #12;
        check_out("reset");
        reset = 1'b0;

        cyc("init", 0, 0, 0, 1, 29, 28);
        check("sp_const", readData1, SP);
        check("gp_const", readData2, GP);

        cyc("wr5", 1, 5, 32'hDEAD_BEEF, 0, 1, 2);
        cyc("rd5", 0, 0, 0, 1, 5, 0);
        check("r5_const", readData1, 32'hDEAD_BEEF);

        cyc("byp7", 1, 7, 32'h1234_5678, 1, 7, 7);
        check("byp7_const", readData2, 32'h1234_5678);

        cyc("wr0", 1, 0, 32'hFFFF_FFFF, 1, 0, 7);
        cyc("rd0", 0, 0, 0, 1, 0, 0);

        cyc("p0", 0, 0, 0, 0, 0, 0);
        cyc("p1", 0, 0, 0, 1, 5, 7);
        cyc("p2", 1, 9, 32'h0BAD_F00D, 1, 29, 5);
        cyc("p3", 0, 0, 0, 0, 9, 9);
        cyc("p4", 0, 0, 0, 1, 9, 28);
        cyc("p5", 0, 0, 0, 0, 1, 1);
        cyc("p6", 0, 0, 0, 0, 3, 3);

        cyc("wr3", 1, 3, 32'hA5A5_A5A5, 0, 0, 0);
        cyc("rd3", 0, 0, 0, 1, 3, 3);
        check("r3_const", readData1, 32'hA5A5_A5A5);
        #2;
        reset = 1'b1;
        mreset();
        #1;
        check_out("async_rst");
        #3;
        reset = 1'b0;
        cyc("rd3_post", 0, 0, 0, 1, 3, 29);
        check("r3_zero", readData1, 32'h0);

        for (int i = 0; i < 400; i++) begin
            logic [4:0] wa;
            logic [4:0] a1;
            logic [4:0] a2;
            if ($urandom_range(0, 1) == 1) begin
                wa = 5'($urandom_range(0, 7));
                a1 = 5'($urandom_range(0, 7));
                a2 = 5'($urandom_range(0, 7));
            end else begin
                wa = 5'($urandom_range(0, 31));
                a1 = 5'($urandom_range(0, 31));
                a2 = 5'($urandom_range(0, 31));
            end
            if ($urandom_range(0, 15) == 0) begin
                cyc("rnd", 1'($urandom), wa, $urandom, 1, a1, a1);
            end else begin
                cyc("rnd", 1'($urandom), wa, $urandom,
                    1'($urandom), a1, a2);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
